// File: rtl/alu_exec.sv
// Execution-stage ALU: single-cycle logic/shift/rotate/add/sub/compare, plus
// iterative WIDTH-cycle shift-add multiply and restoring divide behind a start/busy/done handshake.
module alu_exec #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             lt,
  output logic             gt,
  output logic             div_zero,
  output logic             illegal
);

  localparam logic [3:0] OP_ADD = 4'b1111, OP_SUB = 4'b1110, OP_AND = 4'b1101,
                         OP_OR  = 4'b1100, OP_SLL = 4'b1010, OP_SLR = 4'b1011,
                         OP_ROL = 4'b1000, OP_ROR = 4'b1001, OP_LSW = 4'b0011,
                         OP_CMP = 4'b0100, OP_MUL = 4'b0001, OP_DIV = 4'b0010;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;

  state_e           r_state, w_state_nxt;
  logic [SHW-1:0]   r_cnt;
  logic [WIDTH-1:0] r_wa, r_wb, r_dv;  // hi/rem, lo/quotient, multiplicand/divisor
  logic [WIDTH-1:0] r_result, r_result_hi;
  logic             r_done, r_zero, r_lt, r_gt, r_div_zero, r_illegal;

  logic [SHW-1:0]   w_sh;
  logic [SHW:0]     w_sh_inv;
  logic [WIDTH-1:0] w_res, w_hi;
  logic             w_lt, w_gt, w_dz, w_ill, w_iterate, w_last;
  logic [WIDTH:0]   w_sum, w_rsh;
  logic [WIDTH-1:0] w_mul_hi, w_mul_lo, w_rdiff, w_div_rem, w_div_quo;
  logic             w_ge;

  assign w_sh      = op_b[SHW-1:0];
  assign w_sh_inv  = (SHW+1)'(WIDTH) - {1'b0, w_sh};
  assign w_iterate = (alu_ctrl == OP_MUL) || ((alu_ctrl == OP_DIV) && (op_b != '0));
  assign w_last    = (r_cnt == SHW'(WIDTH-1));

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_res = '0;
    w_hi  = '0;
    w_lt  = 1'b0;
    w_gt  = 1'b0;
    w_dz  = 1'b0;
    w_ill = 1'b0;
    case (alu_ctrl)
      OP_ADD, OP_LSW: w_res = op_a + op_b;
      OP_SUB:         w_res = op_a - op_b;
      OP_AND:         w_res = op_a & op_b;
      OP_OR:          w_res = op_a | op_b;
      OP_SLL:         w_res = op_a << w_sh;
      OP_SLR:         w_res = op_a >> w_sh;
      // a shift by w_sh_inv == WIDTH yields 0, so rotate-by-0 returns op_a
      OP_ROL:         w_res = (op_a << w_sh) | (op_a >> w_sh_inv);
      OP_ROR:         w_res = (op_a >> w_sh) | (op_a << w_sh_inv);
      OP_CMP: begin
        w_res = op_a - op_b;
        w_lt  = $signed(op_a) < $signed(op_b);
        w_gt  = $signed(op_a) > $signed(op_b);
      end
      OP_DIV: begin  // only reaches the outputs when op_b == 0
        w_res = '1;
        w_hi  = op_a;
        w_dz  = 1'b1;
      end
      OP_MUL:         w_res = '0;
      default:        w_ill = 1'b1;
    endcase
  end

  // One shift-add step: conditionally add multiplicand to hi, then shift {carry,hi,lo} right.
  assign w_sum    = {1'b0, r_wa} + (r_wb[0] ? {1'b0, r_dv} : '0);
  assign w_mul_hi = w_sum[WIDTH:1];
  assign w_mul_lo = {w_sum[0], r_wb[WIDTH-1:1]};

  // One restoring-divide step; the difference always fits WIDTH bits when it is kept.
  assign w_rsh     = {r_wa, r_wb[WIDTH-1]};
  assign w_ge      = (w_rsh >= {1'b0, r_dv});
  assign w_rdiff   = w_rsh[WIDTH-1:0] - r_dv;
  assign w_div_rem = w_ge ? w_rdiff : w_rsh[WIDTH-1:0];
  assign w_div_quo = {r_wb[WIDTH-2:0], w_ge};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start && w_iterate) w_state_nxt = (alu_ctrl == OP_MUL) ? S_MUL : S_DIV;
      S_MUL, S_DIV: if (w_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt       <= '0;
      r_wa        <= '0;
      r_wb        <= '0;
      r_dv        <= '0;
      r_result    <= '0;
      r_result_hi <= '0;
      r_done      <= 1'b0;
      r_zero      <= 1'b0;
      r_lt        <= 1'b0;
      r_gt        <= 1'b0;
      r_div_zero  <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_cnt <= '0;
          if (w_iterate) begin
            r_wa <= '0;
            r_wb <= (alu_ctrl == OP_MUL) ? op_b : op_a;
            r_dv <= (alu_ctrl == OP_MUL) ? op_a : op_b;
          end else begin
            r_result    <= w_res;
            r_result_hi <= w_hi;
            r_zero      <= (w_res == '0);
            r_lt        <= w_lt;
            r_gt        <= w_gt;
            r_div_zero  <= w_dz;
            r_illegal   <= w_ill;
            r_done      <= 1'b1;
          end
        end
        S_MUL, S_DIV: begin
          r_cnt <= r_cnt + SHW'(1);
          r_wa  <= (r_state == S_MUL) ? w_mul_hi : w_div_rem;
          r_wb  <= (r_state == S_MUL) ? w_mul_lo : w_div_quo;
          if (w_last) begin
            r_result    <= (r_state == S_MUL) ? w_mul_lo : w_div_quo;
            r_result_hi <= (r_state == S_MUL) ? w_mul_hi : w_div_rem;
            r_zero      <= (((r_state == S_MUL) ? w_mul_lo : w_div_quo) == '0);
            r_lt        <= 1'b0;
            r_gt        <= 1'b0;
            r_div_zero  <= 1'b0;
            r_illegal   <= 1'b0;
            r_done      <= 1'b1;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign result    = r_result;
  assign result_hi = r_result_hi;
  assign zero      = r_zero;
  assign lt        = r_lt;
  assign gt        = r_gt;
  assign div_zero  = r_div_zero;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed vector table plus hand-written
// sequences for back-to-back issue, start during busy, and mid-operation reset.
module tb_alu_exec;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   alu_ctrl = '0;
  logic [W-1:0] op_a = '0, op_b = '0;
  logic         busy, done, zero, lt, gt, div_zero, illegal;
  logic [W-1:0] result, result_hi;

  int total = 0;
  int bad   = 0;

  alu_exec #(.WIDTH(W), .SHW(4)) dut (
    .clk(clk), .rst(rst), .start(start), .alu_ctrl(alu_ctrl),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
    .result(result), .result_hi(result_hi), .zero(zero),
    .lt(lt), .gt(gt), .div_zero(div_zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   ctrl;
    logic [W-1:0] a, b, res, hi;
    logic         z, l, g, dz, ill;
    int           lat;
  } vec_t;

  vec_t vecs[24];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int n;
    string t;
    t = $sformatf("v%0d", idx);
    @(negedge clk);
    alu_ctrl = v.ctrl; op_a = v.a; op_b = v.b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op_a = 16'h5A5A; op_b = 16'hA5A5; alu_ctrl = 4'hF;
    check({t, " busy"}, 32'(busy), 32'(v.lat > 1));
    n = 1;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({t, " latency"}, 32'(n), 32'(v.lat));
    check({t, " result"}, 32'(result), 32'(v.res));
    check({t, " result_hi"}, 32'(result_hi), 32'(v.hi));
    check({t, " flags z/lt/gt/dz/ill"}, {27'd0, zero, lt, gt, div_zero, illegal},
          {27'd0, v.z, v.l, v.g, v.dz, v.ill});
    @(negedge clk);
    check({t, " done pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int dones, at;
    logic [W-1:0] got;

    //         ctrl   a        b        res      hi       z     lt    gt    dz    ill   lat
    vecs[0]  = '{4'hF, 16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vecs[1]  = '{4'hF, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vecs[2]  = '{4'hE, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vecs[3]  = '{4'hE, 16'h0000, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vecs[4]  = '{4'hD, 16'hF0F0, 16'h3C3C, 16'h3030, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vecs[5]  = '{4'hC, 16'hF0F0, 16'h0F0F, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vecs[6]  = '{4'hA, 16'h0001, 16'h000F, 16'h8000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vecs[7]  = '{4'hB, 16'h8000, 16'h0013, 16'h1000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vecs[8]  = '{4'h8, 16'h8001, 16'h0004, 16'h0018, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vecs[9]  = '{4'h9, 16'h8001, 16'h0001, 16'hC000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vecs[10] = '{4'h8, 16'hABCD, 16'h0010, 16'hABCD, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vecs[11] = '{4'h9, 16'h8001, 16'h0000, 16'h8001, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vecs[12] = '{4'h3, 16'h1000, 16'h0234, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vecs[13] = '{4'h4, 16'hFFFE, 16'h0003, 16'hFFFB, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    vecs[14] = '{4'h4, 16'h0040, 16'h0040, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vecs[15] = '{4'h4, 16'h0003, 16'hFFFE, 16'h0005, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1};
    vecs[16] = '{4'h1, 16'd300,  16'd250,  16'h24F8, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 17};
    vecs[17] = '{4'h1, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 17};
    vecs[18] = '{4'h1, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 17};
    vecs[19] = '{4'h2, 16'd1000, 16'd7,    16'h008E, 16'h0006, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 17};
    vecs[20] = '{4'h2, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 17};
    vecs[21] = '{4'h2, 16'h0005, 16'h0009, 16'h0000, 16'h0005, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 17};
    vecs[22] = '{4'h2, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    vecs[23] = '{4'h5, 16'hABCD, 16'h1234, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1};

    // reset state
    repeat (3) @(negedge clk);
    check("reset outputs", {21'd0, busy, done, zero, lt, gt, div_zero, illegal, 4'd0},
          32'd0);
    check("reset result", {result, result_hi}, 32'd0);
    rst = 1'b1;

    // back-to-back single-cycle ops
    @(negedge clk);
    alu_ctrl = 4'hF; op_a = 16'h7FFF; op_b = 16'h0001; start = 1'b1;
    @(negedge clk);
    check("b2b add done", 32'(done), 32'd1);
    check("b2b add result", {15'd0, zero, result}, {15'd0, 1'b0, 16'h8000});
    alu_ctrl = 4'hE; op_a = 16'd5; op_b = 16'd5;
    @(negedge clk);
    start = 1'b0;
    check("b2b sub done", 32'(done), 32'd1);
    check("b2b sub result", {15'd0, zero, result}, {15'd0, 1'b1, 16'h0000});
    @(negedge clk);
    check("b2b done clears", 32'(done), 32'd0);

    for (int i = 0; i < 24; i++) run_vec(vecs[i], i);

    // start during busy is ignored; operands changed mid-flight have no effect
    @(negedge clk);
    alu_ctrl = 4'h1; op_a = 16'd300; op_b = 16'd250; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op_a = 16'h0; op_b = 16'h0;
    dones = 0; at = 0; got = '0;
    for (int i = 1; i <= 24; i++) begin
      if (done) begin
        dones++;
        at = i;
        got = result;
      end
      if (i == 4) begin
        alu_ctrl = 4'hF; op_a = 16'd1; op_b = 16'd1; start = 1'b1;
      end
      if (i == 5) start = 1'b0;
      @(negedge clk);
    end
    check("busy-start done count", 32'(dones), 32'd1);
    check("busy-start done cycle", 32'(at), 32'd17);
    check("busy-start mul result", 32'(got), 32'h24F8);
    check("hold result", {result_hi, result}, 32'h000124F8);

    // reset in the middle of a multiply
    @(negedge clk);
    alu_ctrl = 4'h1; op_a = 16'd300; op_b = 16'd250; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("mid-mul busy", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("mid-rst flags", {24'd0, busy, done, zero, lt, gt, div_zero, illegal, 1'b0}, 32'd0);
    check("mid-rst result", {result_hi, result}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    check("no done after release", 32'(dones), 32'd0);
    run_vec(vecs[0], 100);
    run_vec(vecs[23], 101);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
